// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the memory stage and a byte-addressed data RAM.
// Aligned accesses take one RAM cycle; misaligned half/word accesses are split into byte accesses.
module lsu_ctrl #(
    parameter int unsigned     ADDR    = 32,
    parameter int unsigned     WORD    = 32,
    parameter logic [ADDR-1:0] MEM_TOP = 32'h0000_FFFF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [ADDR-1:0] req_addr,
    input  logic [WORD-1:0] req_wdata,
    output logic            resp_valid,
    output logic [WORD-1:0] resp_rdata,
    output logic            resp_err,
    output logic [ADDR-1:0] mem_addr,
    output logic [1:0]      mem_width,
    output logic            mem_write,
    output logic [WORD-1:0] mem_wdata,
    input  logic [WORD-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ONE  = 2'd1,
        S_BYTE = 2'd2,
        S_RESP = 2'd3
    } state_t;

    function automatic logic [2:0] f_size(input logic [2:0] f3);
        logic [2:0] n;
        case (f3[1:0])
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            2'b10:   n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    function automatic logic f_legal(input logic store, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = ~store;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [WORD-1:0] f_extend(input logic [2:0] f3, input logic [WORD-1:0] raw);
        logic [WORD-1:0] v;
        case (f3)
            3'b000:  v = {{(WORD-8){raw[7]}}, raw[7:0]};
            3'b001:  v = {{(WORD-16){raw[15]}}, raw[15:0]};
            3'b100:  v = {{(WORD-8){1'b0}}, raw[7:0]};
            3'b101:  v = {{(WORD-16){1'b0}}, raw[15:0]};
            default: v = raw;
        endcase
        return v;
    endfunction

    state_t          r_state;
    state_t          w_next;
    logic            r_store;
    logic [2:0]      r_funct3;
    logic [ADDR-1:0] r_addr;
    logic [WORD-1:0] r_wdata;
    logic            r_err;
    logic            r_mis;
    logic [1:0]      r_cnt;
    logic [WORD-1:0] r_acc;

    logic [2:0]      w_req_size;
    logic [ADDR:0]   w_req_end;
    logic            w_req_err;
    logic            w_req_aligned;
    logic            w_accept;
    logic [1:0]      w_last;
    logic [1:0]      w_prev;
    logic [7:0]      w_wbyte;
    logic [WORD-1:0] w_raw;

    // The end address is formed one bit wider so a wrap past the top of the address space is an error.
    assign w_req_size    = f_size(req_funct3);
    assign w_req_end     = {1'b0, req_addr} + {{(ADDR-2){1'b0}}, w_req_size} - {{ADDR{1'b0}}, 1'b1};
    assign w_req_err     = ~f_legal(req_store, req_funct3) | (w_req_end > {1'b0, MEM_TOP});
    assign w_req_aligned = (req_funct3[1:0] == 2'b00) |
                           ((req_funct3[1:0] == 2'b01) & ~req_addr[0]) |
                           ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] == 2'b00));
    assign w_accept      = (r_state == S_IDLE) & req_valid;
    assign w_last        = r_funct3[1] ? 2'd3 : (r_funct3[0] ? 2'd1 : 2'd0);
    assign w_prev        = r_cnt - 2'd1;
    assign w_wbyte       = r_wdata[{r_cnt, 3'b000} +: 8];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_req_err) begin
                        w_next = S_RESP;
                    end else if (w_req_aligned) begin
                        w_next = S_ONE;
                    end else begin
                        w_next = S_BYTE;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ONE:  w_next = S_RESP;
            S_BYTE: begin
                if (r_cnt == w_last) begin
                    w_next = S_RESP;
                end else begin
                    w_next = S_BYTE;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request capture, byte counter and load-byte accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_store  <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
            r_mis    <= 1'b0;
            r_cnt    <= 2'd0;
            r_acc    <= '0;
        end else if (w_accept) begin
            r_store  <= req_store;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_err    <= w_req_err;
            r_mis    <= ~w_req_aligned;
            r_cnt    <= 2'd0;
            r_acc    <= '0;
        end else if (r_state == S_BYTE) begin
            r_cnt <= r_cnt + 2'd1;
            // Read data lags the driven byte by one cycle, so slot i-1 is filled while byte i is driven.
            if (r_cnt != 2'd0) begin
                r_acc[{w_prev, 3'b000} +: 8] <= mem_rdata[7:0];
            end else begin
                r_acc <= r_acc;
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Assemble the load word; the final misaligned byte arrives live during RESP.
    always_comb begin
        w_raw = mem_rdata;
        if (r_mis) begin
            w_raw = r_acc;
            w_raw[{w_last, 3'b000} +: 8] = mem_rdata[7:0];
        end else begin
            w_raw = mem_rdata;
        end
    end

    // Output decode; everything idles at zero outside the access and response states.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_addr   = '0;
        mem_width  = 2'b00;
        mem_write  = 1'b0;
        mem_wdata  = '0;
        case (r_state)
            S_IDLE: req_ready = rst_n;
            S_ONE: begin
                mem_addr  = r_addr;
                mem_width = r_funct3[1:0];
                mem_write = r_store;
                mem_wdata = r_wdata;
            end
            S_BYTE: begin
                mem_addr  = r_addr + {{(ADDR-2){1'b0}}, r_cnt};
                mem_width = 2'b00;
                mem_write = r_store;
                mem_wdata = {{(WORD-8){1'b0}}, w_wbyte};
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                if (r_err | r_store) begin
                    resp_rdata = '0;
                end else begin
                    resp_rdata = f_extend(r_funct3, w_raw);
                end
            end
            default: req_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vector table, hand-written corner sequences,
// and random requests checked against a byte-array reference model.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_width;
    logic        mem_write;
    logic        ram_clr;

    int checks   = 0;
    int failures = 0;

    logic [7:0] ram     [0:65535];
    logic [7:0] ref_mem [0:65535];

    lsu_ctrl #(.ADDR(32), .WORD(32), .MEM_TOP(32'h0000_FFFF)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_width(mem_width), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Byte-addressed RAM with registered, zero-extended read data.
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
            mem_rdata <= 32'h0;
        end else begin
            case (mem_width)
                2'b00:   mem_rdata <= {24'h0, ram[mem_addr[15:0]]};
                2'b01:   mem_rdata <= {16'h0, ram[16'(mem_addr[15:0] + 16'd1)], ram[mem_addr[15:0]]};
                default: mem_rdata <= {ram[16'(mem_addr[15:0] + 16'd3)], ram[16'(mem_addr[15:0] + 16'd2)],
                                       ram[16'(mem_addr[15:0] + 16'd1)], ram[mem_addr[15:0]]};
            endcase
            if (mem_write) begin
                ram[mem_addr[15:0]] <= mem_wdata[7:0];
                if (mem_width != 2'b00) ram[16'(mem_addr[15:0] + 16'd1)] <= mem_wdata[15:8];
                if (mem_width == 2'b10) begin
                    ram[16'(mem_addr[15:0] + 16'd2)] <= mem_wdata[23:16];
                    ram[16'(mem_addr[15:0] + 16'd3)] <= mem_wdata[31:24];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: size/legality/range from the RV32 rules, data from a byte array.
    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         output logic e_err, output logic [31:0] e_data, output int e_lat, output int e_nwr);
        int n;
        logic [32:0] last;
        logic [31:0] v;
        logic [15:0] idx;
        case (f3)
            3'd0: n = 1;
            3'd1: n = 2;
            3'd2: n = 4;
            3'd4: n = st ? 0 : 1;
            3'd5: n = st ? 0 : 2;
            default: n = 0;
        endcase
        last   = {1'b0, a} + 33'(n) - 33'd1;
        e_err  = (n == 0) || (last > 33'h0_0000_FFFF);
        e_data = 32'h0;
        e_lat  = 1;
        e_nwr  = 0;
        if (!e_err) begin
            e_lat = ((a % n) == 0) ? 2 : n + 1;
            if (st) begin
                for (int k = 0; k < n; k++) begin
                    idx = a[15:0] + 16'(k);
                    ref_mem[idx] = wd[8*k +: 8];
                end
                e_nwr = ((a % n) == 0) ? 1 : n;
            end else begin
                v = 32'h0;
                for (int k = 0; k < n; k++) begin
                    idx = a[15:0] + 16'(k);
                    v = v | (32'(ref_mem[idx]) << (8*k));
                end
                if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
                if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
                e_data = v;
            end
        end
    endtask

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          output logic g_err, output logic [31:0] g_data, output int g_lat, output int g_nwr,
                          output logic [31:0] g_a1, output logic [1:0] g_w1, output logic [31:0] g_wd1,
                          output logic g_quiet);
        int n;
        g_err = 1'b0; g_data = 32'h0; g_lat = 0; g_nwr = 0;
        g_a1 = 32'h0; g_w1 = 2'b00; g_wd1 = 32'h0; g_quiet = 1'b1;
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", {31'h0, req_ready}, 32'h1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                g_a1 = mem_addr; g_w1 = mem_width; g_wd1 = mem_wdata;
            end
            if (mem_write) g_nwr++;
            if (resp_valid) begin
                g_lat = c; g_err = resp_err; g_data = resp_rdata;
                break;
            end else if (resp_rdata != 32'h0 || resp_err) begin
                g_quiet = 1'b0;
            end
        end
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] data;
        int          lat;
        int          nwr;
        logic [31:0] a1;
        logic [1:0]  w1;
        logic [31:0] wd1;
    } vec_t;

    localparam int NV = 20;
    vec_t vt [0:NV-1];

    logic        g_err, e_err, g_quiet, saw_resp, take;
    logic [31:0] g_data, e_data, g_a1, g_wd1, rd2;
    logic [1:0]  g_w1;
    int          g_lat, g_nwr, e_lat, e_nwr, a1, a2, nresp, mode;
    logic        r_st;
    logic [2:0]  r_f3;
    logic [31:0] r_a, r_wd;

    initial begin
        //        st    f3     addr           wd             err   data           lat nwr a1             w1     wd1
        vt[0]  = '{1'b1, 3'd2, 32'h0000_0100, 32'h8433_2211, 1'b0, 32'h0,         2, 1, 32'h0000_0100, 2'd2, 32'h8433_2211};
        vt[1]  = '{1'b0, 3'd2, 32'h0000_0100, 32'h0,         1'b0, 32'h8433_2211, 2, 0, 32'h0000_0100, 2'd2, 32'h0};
        vt[2]  = '{1'b0, 3'd0, 32'h0000_0103, 32'h0,         1'b0, 32'hFFFF_FF84, 2, 0, 32'h0000_0103, 2'd0, 32'h0};
        vt[3]  = '{1'b0, 3'd4, 32'h0000_0103, 32'h0,         1'b0, 32'h0000_0084, 2, 0, 32'h0000_0103, 2'd0, 32'h0};
        vt[4]  = '{1'b0, 3'd1, 32'h0000_0102, 32'h0,         1'b0, 32'hFFFF_8433, 2, 0, 32'h0000_0102, 2'd1, 32'h0};
        vt[5]  = '{1'b0, 3'd5, 32'h0000_0102, 32'h0,         1'b0, 32'h0000_8433, 2, 0, 32'h0000_0102, 2'd1, 32'h0};
        vt[6]  = '{1'b1, 3'd2, 32'h0000_0201, 32'hDEAD_BEEF, 1'b0, 32'h0,         5, 4, 32'h0000_0201, 2'd0, 32'h0000_00EF};
        vt[7]  = '{1'b0, 3'd2, 32'h0000_0201, 32'h0,         1'b0, 32'hDEAD_BEEF, 5, 0, 32'h0000_0201, 2'd0, 32'h0};
        vt[8]  = '{1'b0, 3'd2, 32'h0000_FFFE, 32'h0,         1'b1, 32'h0,         1, 0, 32'h0,         2'd0, 32'h0};
        vt[9]  = '{1'b0, 3'd3, 32'h0000_0000, 32'h0,         1'b1, 32'h0,         1, 0, 32'h0,         2'd0, 32'h0};
        vt[10] = '{1'b0, 3'd1, 32'h0000_0101, 32'h0,         1'b0, 32'h0000_3322, 3, 0, 32'h0000_0101, 2'd0, 32'h0};
        vt[11] = '{1'b1, 3'd0, 32'h0000_FFFF, 32'h1234_56A5, 1'b0, 32'h0,         2, 1, 32'h0000_FFFF, 2'd0, 32'h1234_56A5};
        vt[12] = '{1'b0, 3'd0, 32'h0000_FFFF, 32'h0,         1'b0, 32'hFFFF_FFA5, 2, 0, 32'h0000_FFFF, 2'd0, 32'h0};
        vt[13] = '{1'b0, 3'd1, 32'h0000_FFFF, 32'h0,         1'b1, 32'h0,         1, 0, 32'h0,         2'd0, 32'h0};
        vt[14] = '{1'b1, 3'd4, 32'h0000_0000, 32'h0000_0055, 1'b1, 32'h0,         1, 0, 32'h0,         2'd0, 32'h0};
        vt[15] = '{1'b0, 3'd2, 32'hFFFF_FFFF, 32'h0,         1'b1, 32'h0,         1, 0, 32'h0,         2'd0, 32'h0};
        vt[16] = '{1'b1, 3'd1, 32'h0000_0203, 32'h0000_CAFE, 1'b0, 32'h0,         3, 2, 32'h0000_0203, 2'd0, 32'h0000_00FE};
        vt[17] = '{1'b0, 3'd5, 32'h0000_0203, 32'h0,         1'b0, 32'h0000_CAFE, 3, 0, 32'h0000_0203, 2'd0, 32'h0};
        vt[18] = '{1'b0, 3'd2, 32'h0000_0200, 32'h0,         1'b0, 32'hFEBE_EF00, 2, 0, 32'h0000_0200, 2'd2, 32'h0};
        vt[19] = '{1'b0, 3'd2, 32'h0000_FFFC, 32'h0,         1'b0, 32'hA500_0000, 2, 0, 32'h0000_FFFC, 2'd2, 32'h0};

        rst_n = 1'b0; ram_clr = 1'b1;
        req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
        #3;
        chk("reset_ctl", {27'h0, req_ready, resp_valid, resp_err, mem_write, mem_write}, 32'h0);
        chk("reset_width", {30'h0, mem_width}, 32'h0);
        chk("reset_addr", mem_addr, 32'h0);
        chk("reset_wdata", mem_wdata | resp_rdata, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        ram_clr = 1'b0; rst_n = 1'b1;
        #1 chk("ready_after_reset", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < NV; i++) begin
            do_req(vt[i].st, vt[i].f3, vt[i].addr, vt[i].wd,
                   g_err, g_data, g_lat, g_nwr, g_a1, g_w1, g_wd1, g_quiet);
            model(vt[i].st, vt[i].f3, vt[i].addr, vt[i].wd, e_err, e_data, e_lat, e_nwr);
            chk($sformatf("vec%0d_err", i),   {31'h0, g_err}, {31'h0, vt[i].err});
            chk($sformatf("vec%0d_data", i),  g_data, vt[i].data);
            chk($sformatf("vec%0d_lat", i),   32'(g_lat), 32'(vt[i].lat));
            chk($sformatf("vec%0d_nwr", i),   32'(g_nwr), 32'(vt[i].nwr));
            chk($sformatf("vec%0d_addr1", i), g_a1, vt[i].a1);
            chk($sformatf("vec%0d_width1", i), {30'h0, g_w1}, {30'h0, vt[i].w1});
            chk($sformatf("vec%0d_wdata1", i), g_wd1, vt[i].wd1);
            chk($sformatf("vec%0d_quiet", i), {31'h0, g_quiet}, 32'h1);
        end

        // Back-to-back: SB 0x10 then LBU 0x10 with req_valid held.
        a1 = -1; a2 = -1; nresp = 0; rd2 = 32'h0;
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd0; req_addr = 32'h10; req_wdata = 32'h0000_005A;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            take = req_ready && req_valid;
            if (resp_valid) begin
                nresp++;
                if (nresp == 2) rd2 = resp_rdata;
            end
            @(posedge clk);
            #1;
            if (take) begin
                if (a1 < 0) begin
                    a1 = c; req_store = 1'b0; req_funct3 = 3'd4;
                end else begin
                    a2 = c; req_valid = 1'b0;
                end
            end
        end
        model(1'b1, 3'd0, 32'h10, 32'h5A, e_err, e_data, e_lat, e_nwr);
        chk("b2b_gap", 32'(a2 - a1), 32'd3);
        chk("b2b_nresp", 32'(nresp), 32'd2);
        chk("b2b_data", rd2, 32'h0000_005A);

        // Reset during the second byte of a misaligned SW.
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2; req_addr = 32'h301; req_wdata = 32'h1122_3344;
        @(negedge clk);
        for (int n = 0; n < 50 && !req_ready; n++) @(negedge clk);
        chk("rst_seq_accept", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 chk("rst_seq_byte1_addr", mem_addr, 32'h302);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_ctl", {27'h0, req_ready, resp_valid, resp_err, mem_write, 1'b0}, 32'h0);
        chk("rst_mid_width", {30'h0, mem_width}, 32'h0);
        chk("rst_mid_addr", mem_addr, 32'h0);
        chk("rst_mid_data", mem_wdata | resp_rdata, 32'h0);
        saw_resp = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) saw_resp = 1'b1;
        end
        rst_n = 1'b1;
        chk("rst_no_resp", {31'h0, saw_resp}, 32'h0);
        ref_mem[16'h0301] = 8'h44;
        #1 chk("rst_release_ready", {31'h0, req_ready}, 32'h1);
        do_req(1'b0, 3'd4, 32'h301, 32'h0, g_err, g_data, g_lat, g_nwr, g_a1, g_w1, g_wd1, g_quiet);
        chk("rst_byte0_kept", g_data, 32'h0000_0044);
        do_req(1'b0, 3'd4, 32'h302, 32'h0, g_err, g_data, g_lat, g_nwr, g_a1, g_w1, g_wd1, g_quiet);
        chk("rst_byte1_unwritten", g_data, 32'h0);
        do_req(1'b0, 3'd2, 32'h100, 32'h0, g_err, g_data, g_lat, g_nwr, g_a1, g_w1, g_wd1, g_quiet);
        chk("rst_after_lw", g_data, 32'h8433_2211);
        chk("rst_after_lat", 32'(g_lat), 32'd2);

        // Random requests against the reference model.
        for (int i = 0; i < 150; i++) begin
            mode = $urandom_range(0, 9);
            if (mode < 7)      r_a = 32'h400 + 32'($urandom_range(0, 31));
            else if (mode < 9) r_a = 32'hFFF0 + 32'($urandom_range(0, 15));
            else               r_a = $urandom;
            r_st  = 1'($urandom_range(0, 1));
            r_f3  = 3'($urandom_range(0, 7));
            r_wd  = $urandom;
            do_req(r_st, r_f3, r_a, r_wd, g_err, g_data, g_lat, g_nwr, g_a1, g_w1, g_wd1, g_quiet);
            model(r_st, r_f3, r_a, r_wd, e_err, e_data, e_lat, e_nwr);
            chk($sformatf("rnd%0d_err", i),  {31'h0, g_err}, {31'h0, e_err});
            chk($sformatf("rnd%0d_data", i), g_data, e_data);
            chk($sformatf("rnd%0d_lat", i),  32'(g_lat), 32'(e_lat));
            chk($sformatf("rnd%0d_nwr", i),  32'(g_nwr), 32'(e_nwr));
            chk($sformatf("rnd%0d_quiet", i), {31'h0, g_quiet}, 32'h1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
